main_control_fsm: RTL and testbench

Multicycle MIPS main control unit, directly upstream of ALU_control_unit. Decodes the 6-bit instruction opcode and steps through per-instruction states. Each state drives the datapath enables and muxes, plus the ALUop/addi pair consumed by ALU_control_unit. Moore outputs from a registered state; one instruction in flight at a time.

---
 rtl/main_ctrl_pkg.sv | 49 ++++
 rtl/main_ctrl_outdec.sv | 79 +++++++
 rtl/main_control_fsm.sv | 87 ++++++++
 tb/tb_main_control_fsm.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/main_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit: opcodes, ALUop codes,
// FSM states and the datapath control word produced per state.
package main_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       addi;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/main_ctrl_outdec.sv
// Combinational state -> control-word decoder (Moore outputs).
// Zero latency; no flow control, unused encodings decode to an all-zero word.
module main_ctrl_outdec
  import main_ctrl_pkg::*;
(
  input  state_t st,
  output ctrl_t  cw
);

  always_comb begin
    cw = '0;
    case (st)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        cw.alu_src_b = 2'b01;
        cw.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        cw.alu_src_b = 2'b11;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = 2'b10;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_write  = 1'b1;
        cw.iord       = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = 2'b00;
        cw.alu_op    = ALUOP_RTYPE;
      end
      S_RWB: begin
        cw.reg_write  = 1'b1;
        cw.reg_dst    = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = 2'b01;
        cw.instr_done    = 1'b1;
      end
      S_JUMP: begin
        cw.pc_write   = 1'b1;
        cw.pc_source  = 2'b10;
        cw.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = 2'b10;
        cw.alu_op    = ALUOP_ADD;
        cw.addi      = 1'b1;
      end
      S_ADDIWB: begin
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: one instruction in flight, 2-5 cycles each.
// Outputs decode from the registered state; reset gates all write enables immediately.
module main_control_fsm
  import main_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUop,
  output logic               addi,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t cur;
  ctrl_t  cw;
  logic   op_legal;

  // The IR holds opcode stable for the whole instruction, so MEMADR re-reads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:  cur <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: cur <= S_MEMADR;
            OP_R:         cur <= S_EXEC;
            OP_BEQ:       cur <= S_BRANCH;
            OP_J:         cur <= S_JUMP;
            OP_ADDI:      cur <= S_ADDIEX;
            default:      cur <= S_FETCH;
          endcase
        end
        S_MEMADR: cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  cur <= S_MEMWB;
        S_EXEC:   cur <= S_RWB;
        S_ADDIEX: cur <= S_ADDIWB;
        default:  cur <= S_FETCH;
      endcase
    end
  end

  main_ctrl_outdec u_outdec (
    .st (cur),
    .cw (cw)
  );

  assign op_legal = (opcode == OP_R)   || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J)  || (opcode == OP_ADDI);

  assign PCWrite     = cw.pc_write      & ~reset;
  assign PCWriteCond = cw.pc_write_cond & ~reset;
  assign MemRead     = cw.mem_read      & ~reset;
  assign MemWrite    = cw.mem_write     & ~reset;
  assign IRWrite     = cw.ir_write      & ~reset;
  assign RegWrite    = cw.reg_write     & ~reset;
  assign instr_done  = cw.instr_done    & ~reset;
  assign illegal_op  = (cur == S_DECODE) & ~op_legal & ~reset;

  assign IorD     = cw.iord;
  assign MemtoReg = cw.mem_to_reg;
  assign RegDst   = cw.reg_dst;
  assign ALUSrcA  = cw.alu_src_a;
  assign ALUSrcB  = cw.alu_src_b;
  assign PCSource = cw.pc_source;
  assign ALUop    = cw.alu_op;
  assign addi     = cw.addi;
  assign state    = STATE_W'(cur);

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed + randomized bench for main_control_fsm: expected state traces per opcode and
// per-state output words are built from the instruction-level rules.
module tb_main_control_fsm;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       memrd;
    logic       memwr;
    logic       m2r;
    logic       irw;
    logic       regdst;
    logic       regw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       addi;
    logic       done;
    logic       illegal;
    logic [3:0] st;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       RegDst, RegWrite, ALUSrcA, addi, instr_done, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUop;
  logic [3:0] state;

  int checks = 0;
  int fails  = 0;

  logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                6'b000100, 6'b000010, 6'b001000};

  main_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUop(ALUop), .addi(addi), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction-level view: the sequence of states an opcode walks through.
  function automatic void trace_of(input logic [5:0] op, output int tr[$]);
    case (op)
      6'b100011: tr = '{0, 1, 2, 3, 4};
      6'b101011: tr = '{0, 1, 2, 5};
      6'b000000: tr = '{0, 1, 6, 7};
      6'b000100: tr = '{0, 1, 8};
      6'b000010: tr = '{0, 1, 9};
      6'b001000: tr = '{0, 1, 10, 11};
      default:   tr = '{0, 1};
    endcase
  endfunction

  function automatic obs_t expect_of(input int st, input logic [5:0] op, input logic rst);
    obs_t e;
    e = '0;
    e.st = 4'(st);
    case (st)
      0:  begin e.memrd = 1; e.irw = 1; e.pcw = 1; e.srcb = 2'b01; end
      1:  begin e.srcb = 2'b11; e.illegal = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                                         6'b000100, 6'b000010, 6'b001000}); end
      2:  begin e.srca = 1; e.srcb = 2'b10; end
      3:  begin e.memrd = 1; e.iord = 1; end
      4:  begin e.regw = 1; e.m2r = 1; e.done = 1; end
      5:  begin e.memwr = 1; e.iord = 1; e.done = 1; end
      6:  begin e.srca = 1; e.aluop = 2'b10; end
      7:  begin e.regw = 1; e.regdst = 1; e.done = 1; end
      8:  begin e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcsrc = 2'b01; e.done = 1; end
      9:  begin e.pcw = 1; e.pcsrc = 2'b10; e.done = 1; end
      10: begin e.srca = 1; e.srcb = 2'b10; e.addi = 1; end
      11: begin e.regw = 1; e.done = 1; end
      default: e = '0;
    endcase
    if (rst) begin
      e.pcw = 0; e.pcwc = 0; e.memrd = 0; e.memwr = 0;
      e.irw = 0; e.regw = 0; e.done = 0; e.illegal = 0;
    end
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.pcw = PCWrite;   o.pcwc = PCWriteCond; o.iord = IorD;     o.memrd = MemRead;
    o.memwr = MemWrite; o.m2r = MemtoReg;    o.irw = IRWrite;   o.regdst = RegDst;
    o.regw = RegWrite; o.srca = ALUSrcA;     o.srcb = ALUSrcB;  o.pcsrc = PCSource;
    o.aluop = ALUop;   o.addi = addi;        o.done = instr_done;
    o.illegal = illegal_op; o.st = state;
    return o;
  endfunction

  task automatic check(input int st, input logic [5:0] op, input logic rst, input string tag);
    obs_t e, o;
    e = expect_of(st, op, rst);
    o = observe();
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (state %0d op %b)", tag, o, e, st, op);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one instruction from FETCH; abort_at >= 0 raises reset in that trace step.
  task automatic run_instr(input logic [5:0] op, input int abort_at, input string tag);
    int tr[$];
    trace_of(op, tr);
    opcode = op;
    for (int i = 0; i < tr.size(); i++) begin
      #1;
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check(tr[i], op, 1'b1, {tag, "_abort_gate"});
        next_cycle();
        reset = 1'b0;
        return;
      end
      check(tr[i], op, 1'b0, tag);
      next_cycle();
    end
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'b000000;
    next_cycle();
    #1 check(0, opcode, 1'b1, "reset_c1");
    next_cycle();
    #1 check(0, opcode, 1'b1, "reset_c2");
    reset = 1'b0;

    run_instr(6'b100011, -1, "lw");
    run_instr(6'b000000, -1, "rtype");
    run_instr(6'b000100, -1, "beq");
    run_instr(6'b001000, -1, "addi");
    run_instr(6'b101011, -1, "sw");
    run_instr(6'b000010, -1, "j");
    run_instr(6'b111111, -1, "illegal");
    run_instr(6'b100011, 3, "lw_abort_memrd");
    run_instr(6'b000000, 2, "r_abort_exec");

    for (int n = 0; n < 150; n++) begin
      logic [31:0] r;
      logic [5:0]  op;
      int          ab;
      r = $urandom();
      if ($urandom_range(0, 7) < 6) op = legal_ops[$urandom_range(0, 5)];
      else op = r[5:0];
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, ab, "rand");
    end

    #1 check(0, opcode, 1'b0, "final_fetch");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
